// File: rtl/usb_spi_responder_if.sv
// SPI pin bundle between the SoC spi0 controller and the USB register responder.
// Signal names match the board-level pin names.
interface usb_spi_responder_if;
  logic spi_ss_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_ss_n,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_ss_n,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/usb_spi_responder.sv
// SPI mode-0 target emulating a MAX3421E-style 32x8 register file,
// with a parallel local port and a W1C status register driving irq_n.
module usb_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [4:0] STATUS_ADDR = 5'd25
) (
  input  logic                 clk,
  input  logic                 reset_n,
  usb_spi_responder_if.slave   spi,
  input  logic                 loc_we,
  input  logic [4:0]           loc_addr,
  input  logic [7:0]           loc_wdata,
  output logic [7:0]           loc_rdata,
  output logic                 wr_strobe,
  output logic [4:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 irq_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic ss_s, sclk_s, mosi_s;
  logic ss_q, sclk_q;
  logic sclk_rise, sclk_fall, ss_fall;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [6:0] tx_shift;
  logic [7:0] rx_next;
  logic [4:0] addr;
  logic       dir;
  logic       miso_q;
  logic       oe_q;
  logic       byte_done;
  logic       spi_we;

  logic       st_pend;
  logic [4:0] st_addr;
  logic [7:0] st_data;

  logic [7:0] regs [32];
  logic [7:0] status;
  logic [7:0] stat_clr;
  logic [7:0] stat_set;
  logic [7:0] rd_byte;

  // SS_n sync resets low so a frame already in progress at reset
  // release cannot produce a falling edge until SS_n is seen high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_q      <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.spi_ss_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      ss_q      <= ss_s;
      sclk_q    <= sclk_s;
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_fall   = ~ss_s & ss_q;

  assign rx_next   = {rx_shift, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign spi_we    = !ss_s && (state == DATA) && dir && byte_done;

  assign status    = regs[STATUS_ADDR];
  assign rd_byte   = regs[addr];
  assign stat_clr  = (spi_we && addr == STATUS_ADDR) ? rx_next : 8'h00;
  assign stat_set  = (loc_we && loc_addr == STATUS_ADDR) ? loc_wdata : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 7'd0;
      addr     <= 5'd0;
      dir      <= 1'b0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      busy     <= 1'b0;
    end else if (ss_s) begin
      state  <= IDLE;
      miso_q <= 1'b0;
      oe_q   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            tx_shift <= status[6:0];
            miso_q   <= status[7];
            oe_q     <= 1'b1;
            busy     <= 1'b1;
          end
        end
        CMD, DATA: begin
          if (sclk_rise) begin
            rx_shift <= rx_next[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == CMD) begin
                addr  <= rx_next[7:3];
                dir   <= rx_next[1];
                state <= DATA;
              end else begin
                addr <= addr + 5'd1;
              end
            end
          end else if (sclk_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[5:0], 1'b0};
              miso_q   <= tx_shift[6];
            end else if (state == CMD) begin
              tx_shift <= status[6:0];
              miso_q   <= status[7];
            end else if (!dir) begin
              tx_shift <= rd_byte[6:0];
              miso_q   <= rd_byte[7];
            end else begin
              tx_shift <= 7'd0;
              miso_q   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_pend   <= 1'b0;
      st_addr   <= 5'd0;
      st_data   <= 8'd0;
      wr_strobe <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 8'd0;
      irq_n     <= 1'b1;
    end else begin
      st_pend   <= spi_we;
      wr_strobe <= st_pend;
      irq_n     <= ~|status;
      if (spi_we) begin
        st_addr <= addr;
        st_data <= rx_next;
      end
      if (st_pend) begin
        wr_addr <= st_addr;
        wr_data <= st_data;
      end
    end
  end

  // Local write beats a same-cycle SPI write to the same address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (5'(i) == STATUS_ADDR)
          regs[i] <= (regs[i] & ~stat_clr) | stat_set;
        else if (loc_we && loc_addr == 5'(i))
          regs[i] <= loc_wdata;
        else if (spi_we && addr == 5'(i))
          regs[i] <= rx_next;
      end
    end
  end

  assign loc_rdata       = regs[loc_addr];
  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;

endmodule
